conv_mac_engine: RTL
====================

Name: conv_mac_engine

Overview:
Parametrised, multi-channel successor to the single-window convolution unit. It does the following:
- Fetches one KxK kernel from kernel SRAM.
- Fetches N_CH KxK windows in parallel from window SRAM.
- Runs a signed multiply-accumulate per channel.
- Scales, saturates and presents N_CH results with a one-cycle valid/done pulse.

It sits between the SRAM address generators and the NPU writeback stage. Kernel reuse across successive windows is supported.

Parameters:
KERNEL_SIZE, 3, kernel edge K; kernel and window each hold K*K elements
DATA_WIDTH, 8, signed two's-complement width of kernel, window and result elements
N_CH, 2, number of windows processed in parallel; 1..8
ADDR_WIDTH, 6, width of SRAM address outputs; must satisfy 2^ADDR_WIDTH >= K*K
ACC_WIDTH, 2*DATA_WIDTH+4, signed accumulator width per channel
SHIFT, 0, arithmetic right shift applied to the accumulator before saturation

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous, active-low reset
i_start  in  1  start request; sampled only in IDLE
i_skip_kernel  in  1  sampled with i_start; reuse the stored kernel if it is valid
o_busy  out  1  high in every state except IDLE
o_kernel_addr  out  ADDR_WIDTH  kernel SRAM read address
i_kernel_data  in  DATA_WIDTH  kernel SRAM read data, 1-cycle latency
o_window_addr  out  ADDR_WIDTH  window SRAM read address, shared by all channels
i_window_data  in  N_CH*DATA_WIDTH  window data; channel c occupies bits [c*DW +: DW]; 1-cycle latency
o_result  out  N_CH*DATA_WIDTH  per-channel results, same packing as i_window_data
o_result_valid  out  1  one-cycle pulse; o_result is valid
o_done  out  1  one-cycle pulse, coincident with o_result_valid

Behaviour:
- Reset (async on i_rst_n low):
  - State goes to IDLE.
  - All outputs are 0.
  - Internal kernel-valid flag is cleared.
  - Accumulators are cleared.
  - Reset mid-operation aborts with no result pulse.
- States: IDLE, LOAD_KERNEL, LOAD_WINDOWS, CALC, WRITE.
- IDLE:
  - On i_start=1, go to LOAD_WINDOWS if i_skip_kernel=1 and kernel-valid=1.
  - Otherwise go to LOAD_KERNEL.
  - Address counters are zeroed.
- LOAD_KERNEL:
  - Address 0..K*K-1 is issued on consecutive cycles.
  - Data for address n is captured one cycle later into kernel[n].
  - The state lasts K*K+1 cycles.
  - On exit, kernel-valid is set and the state goes to LOAD_WINDOWS.
- LOAD_WINDOWS:
  - Same timing as LOAD_KERNEL on o_window_addr; lasts K*K+1 cycles.
  - All N_CH lanes are captured from the same address.
  - Then go to CALC.
- CALC:
  - Lasts K*K cycles; index i runs 0..K*K-1.
  - Each cycle: acc[c] += sext(kernel[i]) * sext(window[c][i]). The product is full width and the accumulator is ACC_WIDTH.
  - Accumulators are cleared on CALC entry.
- WRITE:
  - Lasts 1 cycle.
  - For each channel, r = acc[c] >>> SHIFT, saturated to [-2^(DW-1), 2^(DW-1)-1].
  - o_result is registered.
  - o_result_valid=1 and o_done=1 for exactly this cycle.
  - Then go to IDLE.
- o_result holds its last value until the next WRITE or reset.
- Addresses hold their last value outside the load states.
- Latency from the start-accept edge to the valid pulse: 3*K*K+3 cycles with a kernel load (30 for K=3); 2*K*K+2 cycles on a skip (20 for K=3).
- i_start while busy is ignored and not queued.
- i_skip_kernel=1 with kernel-valid=0 forces a kernel load.
- Back-to-back: a start asserted in the IDLE cycle right after WRITE is accepted. The minimum gap between pulses is latency+1.

Optional Feature:
RELU_EN
- Defined: after saturation, negative per-channel results are forced to 0.
- Undefined: signed saturated results pass through unchanged.
- Timing and latency are identical in both cases.

Test Plan:
- Basic:
  - Stimulus: K=3, N_CH=2, SHIFT=0, kernel all 1, ch0 window 1..9, ch1 window all 2.
  - Response: ch0=45, ch1=18; single valid/done pulse 30 cycles after start; o_busy high throughout.
- Saturation:
  - Stimulus: kernel all 1, ch0 all 127, ch1 all -128.
  - Response: ch0=127 (acc 1143), ch1=-128 (acc -1152).
- Signed/ReLU:
  - Stimulus: kernel all -1, window 1..9.
  - Response: -45 without RELU_EN; 0 with RELU_EN.
- Kernel reuse:
  - Stimulus: second start with i_skip_kernel=1.
  - Response: no kernel address sweep; result after 20 cycles uses the stored kernel.
  - Stimulus: i_skip_kernel=1 immediately after reset.
  - Response: kernel is loaded; latency 30.
- Busy start:
  - Stimulus: pulse i_start during CALC.
  - Response: ignored; exactly one result pulse.
- Reset mid-op:
  - Stimulus: drop i_rst_n during LOAD_WINDOWS.
  - Response: all outputs 0 immediately; no pulse; next start with skip=1 still reloads the kernel.

Source files
------------

// File: rtl/conv_mac_engine.sv
// conv_mac_engine: multi-channel KxK signed convolution MAC engine.
// Loads one kernel and N_CH windows from SRAM and runs a signed MAC per channel.
// Each channel result is shifted, saturated and presented with a valid/done pulse.
// The stored kernel can be reused across successive starts.
// Optional build macro RELU_EN: when defined, negative saturated results are clamped to 0.
module conv_mac_engine #(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int N_CH        = 2,
    parameter int ADDR_WIDTH  = 6,
    parameter int ACC_WIDTH   = 2*DATA_WIDTH+4,
    parameter int SHIFT       = 0
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_start,
    input  logic                         i_skip_kernel,
    output logic                         o_busy,
    output logic [ADDR_WIDTH-1:0]        o_kernel_addr,
    input  logic [DATA_WIDTH-1:0]        i_kernel_data,
    output logic [ADDR_WIDTH-1:0]        o_window_addr,
    input  logic [N_CH*DATA_WIDTH-1:0]   i_window_data,
    output logic [N_CH*DATA_WIDTH-1:0]   o_result,
    output logic                         o_result_valid,
    output logic                         o_done
);

    localparam int KK    = KERNEL_SIZE*KERNEL_SIZE;
    localparam int CNT_W = $clog2(KK+1);
    // Storage depth matches the counter width so indexing needs no width adaptation
    localparam int DEPTH = 2**CNT_W;

    localparam logic [CNT_W-1:0] LAST_LOAD = CNT_W'(KK);
    localparam logic [CNT_W-1:0] LAST_CALC = CNT_W'(KK-1);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (DATA_WIDTH-1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_KERNEL,
        ST_LOAD_WINDOWS,
        ST_CALC,
        ST_WRITE
    } state_t;

    state_t                  state_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [CNT_W-1:0]        load_idx;
    logic                    kernel_valid_reg;
    logic                    busy_reg;
    logic                    valid_reg;
    logic [ADDR_WIDTH-1:0]   kernel_addr_reg;
    logic [ADDR_WIDTH-1:0]   window_addr_reg;

    logic signed [DATA_WIDTH-1:0] kernel_mem [DEPTH];

    // Read data arrives one cycle after its address, so load slot n lands at count n+1
    assign load_idx = cnt_reg - 1'b1;

    // Sequencer: state, shared counter, addresses, kernel-valid flag and status outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg        <= ST_IDLE;
            cnt_reg          <= '0;
            kernel_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
            valid_reg        <= 1'b0;
            kernel_addr_reg  <= '0;
            window_addr_reg  <= '0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (i_start) begin
                        cnt_reg  <= '0;
                        busy_reg <= 1'b1;
                        if (i_skip_kernel && kernel_valid_reg) begin
                            state_reg       <= ST_LOAD_WINDOWS;
                            window_addr_reg <= '0;
                        end else begin
                            state_reg       <= ST_LOAD_KERNEL;
                            kernel_addr_reg <= '0;
                        end
                    end
                end
                ST_LOAD_KERNEL: begin
                    if (cnt_reg == LAST_LOAD) begin
                        state_reg        <= ST_LOAD_WINDOWS;
                        cnt_reg          <= '0;
                        kernel_valid_reg <= 1'b1;
                        window_addr_reg  <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg < LAST_CALC) begin
                            kernel_addr_reg <= ADDR_WIDTH'(cnt_reg + 1'b1);
                        end
                    end
                end
                ST_LOAD_WINDOWS: begin
                    if (cnt_reg == LAST_LOAD) begin
                        state_reg <= ST_CALC;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg < LAST_CALC) begin
                            window_addr_reg <= ADDR_WIDTH'(cnt_reg + 1'b1);
                        end
                    end
                end
                ST_CALC: begin
                    if (cnt_reg == LAST_CALC) begin
                        state_reg <= ST_WRITE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_WRITE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    valid_reg <= 1'b1;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Kernel capture: one element per cycle during the kernel load sweep
    always_ff @(posedge i_clk) begin
        if (state_reg == ST_LOAD_KERNEL && cnt_reg != '0) begin
            kernel_mem[load_idx] <= i_kernel_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic signed [DATA_WIDTH-1:0]   window_mem [DEPTH];
            logic signed [2*DATA_WIDTH-1:0] prod;
            logic signed [ACC_WIDTH-1:0]    prod_ext;
            logic signed [ACC_WIDTH-1:0]    acc_reg;
            logic signed [ACC_WIDTH-1:0]    shifted;
            logic signed [DATA_WIDTH-1:0]   lane_next;
            logic signed [DATA_WIDTH-1:0]   result_reg;

            // Window capture: every lane samples its slice of the shared read word
            always_ff @(posedge i_clk) begin
                if (state_reg == ST_LOAD_WINDOWS && cnt_reg != '0) begin
                    window_mem[load_idx] <= i_window_data[gi*DATA_WIDTH +: DATA_WIDTH];
                end
            end

            // Full-width signed product, sign-extended into the accumulator width
            assign prod     = kernel_mem[cnt_reg] * window_mem[cnt_reg];
            assign prod_ext = prod;
            assign shifted  = acc_reg >>> SHIFT;

            // Accumulator: cleared on the edge entering CALC, then one MAC per CALC cycle
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    acc_reg <= '0;
                end else if (state_reg == ST_LOAD_WINDOWS && cnt_reg == LAST_LOAD) begin
                    acc_reg <= '0;
                end else if (state_reg == ST_CALC) begin
                    acc_reg <= acc_reg + prod_ext;
                end
            end

            // Saturate the scaled accumulator to the result element range
            always_comb begin
                lane_next = shifted[DATA_WIDTH-1:0];
                if (shifted > SAT_MAX) begin
                    lane_next = SAT_MAX[DATA_WIDTH-1:0];
                end else if (shifted < SAT_MIN) begin
                    lane_next = SAT_MIN[DATA_WIDTH-1:0];
                end
`ifdef RELU_EN
                if (lane_next[DATA_WIDTH-1]) begin
                    lane_next = '0;
                end
`else
`endif
            end

            // Result register: updated only in WRITE, otherwise holds
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    result_reg <= '0;
                end else if (state_reg == ST_WRITE) begin
                    result_reg <= lane_next;
                end
            end

            assign o_result[gi*DATA_WIDTH +: DATA_WIDTH] = result_reg;
        end
    endgenerate

    assign o_busy         = busy_reg;
    assign o_kernel_addr  = kernel_addr_reg;
    assign o_window_addr  = window_addr_reg;
    assign o_result_valid = valid_reg;
    assign o_done         = valid_reg;

endmodule
